scene_painter: RTL and testbench

SCENE_PAINTER -- requirements
Module: scene_painter

---
 rtl/scene_pkg.sv | 57 +++++
 rtl/alien_grid_hit.sv | 68 ++++++
 rtl/scene_painter.sv | 148 ++++++++++++++
 tb/tb_scene_painter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scene_pkg.sv
// -----------------------------------------------------------------------------
// scene_pkg
// Shared definitions for the scene painter and the downstream RGB palette
// stage: colour codes, screen/sprite geometry and a box-span helper.
// -----------------------------------------------------------------------------
package scene_pkg;

    // Colour codes presented to the palette stage.
    typedef enum logic [2:0] {
        COL_BACKGROUND = 3'd0,
        COL_SPACESHIP  = 3'd1,
        COL_ALIENS0    = 3'd2,
        COL_ALIENS1    = 3'd3,
        COL_ALIENS2    = 3'd4,
        COL_ALIENS3    = 3'd5,
        COL_LASER      = 3'd6,
        COL_NONE       = 3'd7
    } color_e;

    // Visible screen size.
    localparam logic [10:0] SCREEN_W   = 11'd640;
    localparam logic [10:0] SCREEN_H   = 11'd480;

    // Spaceship: fixed row band, 32 px wide.
    localparam logic [9:0]  SHIP_Y_TOP = 10'd448;
    localparam logic [10:0] SHIP_W     = 11'd32;
    localparam logic [10:0] SHIP_H     = 11'd16;

    // Laser bolt size.
    localparam logic [10:0] LASER_W    = 11'd2;
    localparam logic [10:0] LASER_H    = 11'd8;

    // Alien formation: 4 rows x 8 columns of 24x16 sprites on a 32x24 pitch.
    localparam int unsigned GRID_COLS  = 8;
    localparam int unsigned GRID_ROWS  = 4;
    localparam logic [10:0] ALIEN_W    = 11'd24;
    localparam logic [10:0] ALIEN_H    = 11'd16;
    localparam logic [10:0] PITCH_X    = 11'd32;
    localparam logic [10:0] PITCH_Y    = 11'd24;
    localparam logic [10:0] GRID_W     = 11'd256;
    localparam logic [10:0] GRID_H     = 11'd96;

    // True when pos lies in [lo, lo+len-1]; the upper edge is formed in 11 bits
    // so a box starting near 1023 cannot wrap round to low coordinates.
    function automatic logic in_span(input logic [9:0]  pos,
                                     input logic [9:0]  lo,
                                     input logic [10:0] len);
        logic [10:0] pos_w;
        logic [10:0] lo_w;
        logic [10:0] hi_w;
        pos_w = {1'b0, pos};
        lo_w  = {1'b0, lo};
        hi_w  = lo_w + len;
        return (pos_w >= lo_w) && (pos_w < hi_w);
    endfunction

endpackage

// File: rtl/alien_grid_hit.sv
// -----------------------------------------------------------------------------
// alien_grid_hit
// Combinational hit test of one pixel against the alien formation.
//   px_x, px_y         : pixel position
//   origin_x, origin_y : formation top-left
//   alive              : alive mask, bit index = row*8 + col
//   hit                : pixel is on a live alien sprite
//   row                : formation row of that sprite (valid when hit)
// -----------------------------------------------------------------------------
module alien_grid_hit
    import scene_pkg::*;
(
    input  logic [9:0]  px_x,
    input  logic [9:0]  px_y,
    input  logic [9:0]  origin_x,
    input  logic [9:0]  origin_y,
    input  logic [31:0] alive,
    output logic        hit,
    output logic [1:0]  row
);

    // Offsets from the origin in 11-bit two's complement; bit 10 is the sign.
    logic [10:0] dx_s;
    logic [10:0] dy_s;
    logic [2:0]  col_s;
    logic [10:0] yoff_s;
    logic [10:0] xoff_s;
    logic        in_grid_s;

    assign dx_s = {1'b0, px_x} - {1'b0, origin_x};
    assign dy_s = {1'b0, px_y} - {1'b0, origin_y};

    // Locate the cell and test the sprite box inside it.
    always_comb begin
        row       = 2'd0;
        col_s     = 3'd0;
        yoff_s    = 11'd0;
        xoff_s    = 11'd0;
        hit       = 1'b0;
        in_grid_s = !dx_s[10] && !dy_s[10] && (dx_s < GRID_W) && (dy_s < GRID_H);

        // Horizontal pitch is a power of two, so column and offset are bit fields.
        col_s  = dx_s[7:5];
        xoff_s = {6'd0, dx_s[4:0]};

        // Vertical pitch of 24 is not a power of two: pick the row band.
        if (dy_s < PITCH_Y) begin
            row    = 2'd0;
            yoff_s = dy_s;
        end else if (dy_s < (PITCH_Y + PITCH_Y)) begin
            row    = 2'd1;
            yoff_s = dy_s - PITCH_Y;
        end else if (dy_s < (PITCH_Y + PITCH_Y + PITCH_Y)) begin
            row    = 2'd2;
            yoff_s = dy_s - (PITCH_Y + PITCH_Y);
        end else begin
            row    = 2'd3;
            yoff_s = dy_s - (PITCH_Y + PITCH_Y + PITCH_Y);
        end

        if (in_grid_s && (xoff_s < ALIEN_W) && (yoff_s < ALIEN_H)) begin
            hit = alive[{row, col_s}];
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/scene_painter.sv
// -----------------------------------------------------------------------------
// scene_painter
// Two-stage pixel colour generator for a space-shooter scene.
//   clk, rst               : pixel clock, synchronous active-high reset
//   px_x, px_y, video_on   : current pixel and visibility
//   frame_start            : per-frame strobe; latches the object positions
//   ship_x, alien_*, laser_*: live object state (sampled only on frame_start)
//   color, color_valid     : colour code and visibility, 2 cycles after px
// -----------------------------------------------------------------------------
module scene_painter
    import scene_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  px_x,
    input  logic [9:0]  px_y,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic [9:0]  ship_x,
    input  logic [9:0]  alien_x,
    input  logic [9:0]  alien_y,
    input  logic [31:0] alien_alive,
    input  logic [9:0]  laser_x,
    input  logic [9:0]  laser_y,
    input  logic        laser_active,
    output logic [2:0]  color,
    output logic        color_valid
);

    // Shadow copies of object state, stable for a whole frame.
    logic [9:0]  ship_x_q;
    logic [9:0]  alien_x_q;
    logic [9:0]  alien_y_q;
    logic [31:0] alien_alive_q;
    logic [9:0]  laser_x_q;
    logic [9:0]  laser_y_q;
    logic        laser_active_q;

    // Stage 1: registered visibility and hit flags.
    logic        video_on_q;
    logic        ship_hit_q;
    logic        laser_hit_q;
    logic        alien_hit_q;
    logic [1:0]  alien_row_q;

    // Stage 2: registered colour.
    color_e      color_d;
    color_e      color_q;
    logic        color_valid_q;

    logic        ship_hit_s;
    logic        laser_hit_s;
    logic        alien_hit_s;
    logic [1:0]  alien_row_s;

    // Hit flags are formed from the incoming pixel and the current shadows,
    // so a pixel coinciding with frame_start still sees the previous frame.
    assign ship_hit_s  = in_span(px_x, ship_x_q, SHIP_W) &&
                         in_span(px_y, SHIP_Y_TOP, SHIP_H);
    assign laser_hit_s = laser_active_q &&
                         in_span(px_x, laser_x_q, LASER_W) &&
                         in_span(px_y, laser_y_q, LASER_H);

    alien_grid_hit u_alien_grid_hit (
        .px_x     (px_x),
        .px_y     (px_y),
        .origin_x (alien_x_q),
        .origin_y (alien_y_q),
        .alive    (alien_alive_q),
        .hit      (alien_hit_s),
        .row      (alien_row_s)
    );

    // Shadow register capture on frame_start; reset wins over the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ship_x_q       <= 10'd0;
            alien_x_q      <= 10'd0;
            alien_y_q      <= 10'd0;
            alien_alive_q  <= 32'd0;
            laser_x_q      <= 10'd0;
            laser_y_q      <= 10'd0;
            laser_active_q <= 1'b0;
        end else if (frame_start) begin
            ship_x_q       <= ship_x;
            alien_x_q      <= alien_x;
            alien_y_q      <= alien_y;
            alien_alive_q  <= alien_alive;
            laser_x_q      <= laser_x;
            laser_y_q      <= laser_y;
            laser_active_q <= laser_active;
        end
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            video_on_q  <= 1'b0;
            ship_hit_q  <= 1'b0;
            laser_hit_q <= 1'b0;
            alien_hit_q <= 1'b0;
            alien_row_q <= 2'd0;
        end else begin
            video_on_q  <= video_on;
            ship_hit_q  <= ship_hit_s;
            laser_hit_q <= laser_hit_s;
            alien_hit_q <= alien_hit_s;
            alien_row_q <= alien_row_s;
        end
    end

    // Priority encode the stage 1 flags into a colour code.
    always_comb begin
        color_d = COL_BACKGROUND;
        if (!video_on_q) begin
            color_d = COL_NONE;
        end else if (laser_hit_q) begin
            color_d = COL_LASER;
        end else if (ship_hit_q) begin
            color_d = COL_SPACESHIP;
        end else if (alien_hit_q) begin
            case (alien_row_q)
                2'd0:    color_d = COL_ALIENS0;
                2'd1:    color_d = COL_ALIENS1;
                2'd2:    color_d = COL_ALIENS2;
                2'd3:    color_d = COL_ALIENS3;
                default: color_d = COL_BACKGROUND;
            endcase
        end else begin
            color_d = COL_BACKGROUND;
        end
    end

    // Stage 2 output register; idles at NONE/invalid out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_q       <= COL_NONE;
            color_valid_q <= 1'b0;
        end else begin
            color_q       <= color_d;
            color_valid_q <= video_on_q;
        end
    end

    assign color       = color_q;
    assign color_valid = color_valid_q;

endmodule

// File: tb/tb_scene_painter.sv
module tb_scene_painter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  px_x, px_y;
    logic        video_on, frame_start;
    logic [9:0]  ship_x, alien_x, alien_y, laser_x, laser_y;
    logic [31:0] alien_alive;
    logic        laser_active;
    logic [2:0]  color;
    logic        color_valid;

    int checks = 0;
    int errors = 0;

    scene_painter dut (
        .clk          (clk),
        .rst          (rst),
        .px_x         (px_x),
        .px_y         (px_y),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .ship_x       (ship_x),
        .alien_x      (alien_x),
        .alien_y      (alien_y),
        .alien_alive  (alien_alive),
        .laser_x      (laser_x),
        .laser_y      (laser_y),
        .laser_active (laser_active),
        .color        (color),
        .color_valid  (color_valid)
    );

    always #5 clk = ~clk;

    // Reference model state: latched scene plus a 2-deep output delay line.
    typedef struct {
        int          sx, ax, ay, lx, ly;
        bit          la;
        logic [31:0] alive;
    } shadow_t;

    shadow_t sh;
    int m_s1c = 7, m_s2c = 7;
    int m_s1v = 0, m_s2v = 0;

    typedef struct {
        string       name;
        int          sx, ax, ay, lx, ly, la;
        logic [31:0] alive;
        int          px, py, exp;
    } vec_t;

    vec_t vecs[$];

    function automatic int model_color(input shadow_t s, input int x, input int y, input bit vid);
        int dx, dy, r, c;
        if (!vid) return 7;
        if (s.la && x >= s.lx && x <= s.lx + 1 && y >= s.ly && y <= s.ly + 7) return 6;
        if (x >= s.sx && x <= s.sx + 31 && y >= 448 && y <= 463) return 1;
        dx = x - s.ax;
        dy = y - s.ay;
        if (dx >= 0 && dx < 256 && dy >= 0 && dy < 96) begin
            c = dx / 32;
            r = dy / 24;
            if ((dx % 32) < 24 && (dy % 24) < 16 && s.alive[r * 8 + c]) return 2 + r;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: advance the model with the currently driven inputs, then compare.
    task automatic step();
        if (rst) begin
            m_s1c = 7; m_s1v = 0; m_s2c = 7; m_s2v = 0;
            sh.sx = 0; sh.ax = 0; sh.ay = 0; sh.lx = 0; sh.ly = 0; sh.la = 0; sh.alive = 32'd0;
        end else begin
            m_s2c = m_s1c;
            m_s2v = m_s1v;
            m_s1c = model_color(sh, int'(px_x), int'(px_y), video_on);
            m_s1v = int'(video_on);
            if (frame_start) begin
                sh.sx = int'(ship_x); sh.ax = int'(alien_x); sh.ay = int'(alien_y);
                sh.lx = int'(laser_x); sh.ly = int'(laser_y); sh.la = laser_active;
                sh.alive = alien_alive;
            end
        end
        @(posedge clk);
        #1;
        check("model_color", 32'(color), 32'(m_s2c));
        check("model_valid", 32'(color_valid), 32'(m_s2v));
    endtask

    task automatic load_scene(input vec_t v);
        ship_x = 10'(v.sx); alien_x = 10'(v.ax); alien_y = 10'(v.ay);
        laser_x = 10'(v.lx); laser_y = 10'(v.ly); laser_active = (v.la != 0);
        alien_alive = v.alive;
    endtask

    // Present one visible pixel and return the colour seen two cycles later.
    task automatic probe(input int x, input int y, output logic [2:0] c);
        px_x = 10'(x); px_y = 10'(y); video_on = 1'b1;
        step();
        video_on = 1'b0;
        step();
        c = color;
    endtask

    task automatic add_vec(input string n, input int sx, input int ax, input int ay,
                           input logic [31:0] alive, input int lx, input int ly,
                           input int la, input int px, input int py, input int exp);
        vec_t v;
        v.name = n; v.sx = sx; v.ax = ax; v.ay = ay; v.alive = alive;
        v.lx = lx; v.ly = ly; v.la = la; v.px = px; v.py = py; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [2:0] c;
        logic [31:0] all_alive;
        logic [31:0] no26;
        all_alive = 32'hFFFF_FFFF;
        no26      = 32'hFBFF_FFFF;

        //       name          ship  ax   ay  alive      lx   ly  la  px   py  exp
        add_vec("ship_in",     100,  0,   0,  32'd0,     0,   0,  0, 110, 450, 1);
        add_vec("ship_right",  100,  0,   0,  32'd0,     0,   0,  0, 132, 450, 0);
        add_vec("ship_edge",   100,  0,   0,  32'd0,     0,   0,  0, 131, 463, 1);
        add_vec("ship_below",  100,  0,   0,  32'd0,     0,   0,  0, 100, 464, 0);
        add_vec("ship_left",   100,  0,   0,  32'd0,     0,   0,  0,  99, 448, 0);
        add_vec("alien_r3",    500, 64,  40,  all_alive, 0,   0,  0, 133, 115, 5);
        add_vec("alien_dead",  500, 64,  40,  no26,      0,   0,  0, 133, 115, 0);
        add_vec("alien_gap",   500, 64,  40,  all_alive, 0,   0,  0,  94,  45, 0);
        add_vec("alien_r0",    500, 64,  40,  all_alive, 0,   0,  0,  87,  55, 2);
        add_vec("alien_xgap",  500, 64,  40,  all_alive, 0,   0,  0,  88,  40, 0);
        add_vec("alien_ygap",  500, 64,  40,  all_alive, 0,   0,  0,  64,  56, 0);
        add_vec("alien_r1c7",  500, 64,  40,  all_alive, 0,   0,  0, 311,  64, 3);
        add_vec("laser_ship",  100,  0,   0,  32'd0,   110, 450,  1, 110, 452, 6);
        add_vec("laser_off",   100,  0,   0,  32'd0,   110, 450,  0, 110, 452, 1);
        add_vec("laser_edge",  600,  0,   0,  32'd0,   200, 300,  1, 201, 307, 6);
        add_vec("laser_right", 600,  0,   0,  32'd0,   200, 300,  1, 202, 300, 0);
        add_vec("ship_wrap",  1020,  0,   0,  32'd0,     0,   0,  0,   3, 450, 0);
        add_vec("alien_neg",   500, 600, 40,  all_alive, 0,   0,  0,  10,  45, 0);

        rst = 1'b1; video_on = 1'b0; frame_start = 1'b0; px_x = 10'd0; px_y = 10'd0;
        ship_x = 10'd0; alien_x = 10'd0; alien_y = 10'd0; alien_alive = 32'd0;
        laser_x = 10'd0; laser_y = 10'd0; laser_active = 1'b0;
        sh.sx = 0; sh.ax = 0; sh.ay = 0; sh.lx = 0; sh.ly = 0; sh.la = 0; sh.alive = 32'd0;

        for (int i = 0; i < 3; i++) step();
        check("reset_color", 32'(color), 32'd7);
        check("reset_valid", 32'(color_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("blank_color", 32'(color), 32'd7);
            check("blank_valid", 32'(color_valid), 32'd0);
        end

        // Table-driven scenes: latch with frame_start, then probe one pixel.
        foreach (vecs[i]) begin
            load_scene(vecs[i]);
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            probe(vecs[i].px, vecs[i].py, c);
            check(vecs[i].name, 32'(c), 32'(vecs[i].exp));
        end

        // Live ship_x change without frame_start must not move the ship.
        vecs[0].alive = 32'd0;
        load_scene(vecs[0]);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        ship_x = 10'd300;
        probe(110, 450, c);
        check("no_tear", 32'(c), 32'd1);
        probe(110, 450, c);
        check("no_tear2", 32'(c), 32'd1);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        probe(110, 450, c);
        check("after_fs", 32'(c), 32'd0);

        // Strobe coinciding with a visible pixel: that pixel sees the old shadows.
        ship_x = 10'd100; frame_start = 1'b1; step();
        ship_x = 10'd300; frame_start = 1'b1;
        px_x = 10'd110; px_y = 10'd450; video_on = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        check("fs_same_cycle", 32'(color), 32'd1);
        video_on = 1'b0;
        probe(110, 450, c);
        check("fs_next_pixel", 32'(c), 32'd0);

        // Reset overrides a simultaneous frame_start.
        ship_x = 10'd100; alien_alive = all_alive; alien_x = 10'd100; alien_y = 10'd440;
        rst = 1'b1; frame_start = 1'b1;
        step();
        rst = 1'b0; frame_start = 1'b0;
        step();
        check("rst_hold_color", 32'(color), 32'd7);
        probe(110, 450, c);
        check("rst_over_fs", 32'(c), 32'd0);

        // Randomised traffic checked cycle by cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(299, 0) == 0);
            frame_start  = ($urandom_range(15, 0) == 0);
            video_on     = ($urandom_range(3, 0) != 0);
            ship_x       = 10'($urandom_range(1023, 0));
            alien_x      = 10'($urandom_range(700, 0));
            alien_y      = 10'($urandom_range(400, 0));
            alien_alive  = $urandom;
            laser_x      = 10'($urandom_range(1023, 0));
            laser_y      = 10'($urandom_range(1023, 0));
            laser_active = 1'($urandom_range(1, 0));
            if ($urandom_range(2, 0) == 0) begin
                px_x = 10'($urandom_range(1023, 0));
                px_y = 10'($urandom_range(470, 440));
            end else if ($urandom_range(1, 0) == 0) begin
                px_x = 10'(int'(alien_x) + $urandom_range(260, 0));
                px_y = 10'(int'(alien_y) + $urandom_range(100, 0));
            end else begin
                px_x = 10'($urandom_range(1023, 0));
                px_y = 10'($urandom_range(1023, 0));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
